// File: rtl/npc_sim_pkg.sv
// Shared types and constants for the NPC simulation-halt monitor.
package npc_sim_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam logic [1:0] TRAP_GOOD    = 2'd0;
  localparam logic [1:0] TRAP_BAD     = 2'd1;
  localparam logic [1:0] TRAP_ECALL   = 2'd2;
  localparam logic [1:0] TRAP_TIMEOUT = 2'd3;

  localparam logic [31:0] INST_EBREAK = 32'h00100073;
  localparam logic [31:0] INST_ECALL  = 32'h00000073;

  // Trap code for an instruction-triggered halt; ecall ignores a0.
  function automatic logic [1:0] inst_trap_code(input logic is_ecall, input logic a0_zero);
    if (is_ecall)     return TRAP_ECALL;
    else if (a0_zero) return TRAP_GOOD;
    else              return TRAP_BAD;
  endfunction

endpackage

// File: rtl/npc_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module npc_sat_counter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // Count enabled cycles, holding once the maximum value is reached.
  always_ff @(posedge clk) begin
    if (rst)                   r_q <= '0;
    else if (en && (r_q != '1)) r_q <= r_q + W'(1);
  end

  assign q = r_q;

endmodule

// File: rtl/npc_trap_monitor.sv
// Simulation-halt monitor: detects ebreak/ecall/no-progress, drains, then
// parks in a sticky HALTED state reporting the trap and run statistics.
module npc_trap_monitor
  import npc_sim_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int CNT_W        = 64,
  parameter int DRAIN_CYCLES = 2,
  parameter int TIMEOUT      = 100000,
  parameter int ECALL_TRAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst,
  input  logic             inst_valid,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  a0,
  output logic             halt,
  output logic             trap_valid,
  output logic [1:0]       trap_code,
  output logic [XLEN-1:0]  exit_value,
  output logic [XLEN-1:0]  trap_pc,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  // Counters only ever need to reach their terminal value.
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [WD_W-1:0]    WD_LAST    = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e               r_state;
  state_e               w_state_next;
  logic [DRAIN_W-1:0]   r_drain;
  logic [WD_W-1:0]      r_wd;
  logic [XLEN-1:0]      r_last_pc;
  logic                 r_halt;
  logic                 r_trap_valid;
  logic [1:0]           r_trap_code;
  logic [XLEN-1:0]      r_exit_value;
  logic [XLEN-1:0]      r_trap_pc;

  logic w_run;
  logic w_retire;
  logic w_is_ebreak;
  logic w_is_ecall;
  logic w_inst_trap;
  logic w_timeout;
  logic w_drain_done;

  // Only RUN observes the CPU; inst is qualified by inst_valid before any compare.
  assign w_run        = (r_state == RUN);
  assign w_retire     = w_run && inst_valid;
  assign w_is_ebreak  = w_retire && (inst == INST_EBREAK);
  assign w_is_ecall   = w_retire && (ECALL_TRAP != 0) && (inst == INST_ECALL);
  assign w_inst_trap  = w_is_ebreak || w_is_ecall;
  // A retiring instruction clears the watchdog, so an instruction trap always wins.
  assign w_timeout    = (TIMEOUT != 0) && w_run && !inst_valid && (r_wd == WD_LAST);
  assign w_drain_done = (r_state == DRAIN) && (r_drain == DRAIN_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_next;
  end

  // Next-state: RUN -> DRAIN (or straight to HALTED) -> HALTED, sticky until reset.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      RUN:     if (w_inst_trap || w_timeout)
                 w_state_next = (DRAIN_CYCLES == 0) ? HALTED : DRAIN;
      DRAIN:   if (w_drain_done) w_state_next = HALTED;
      HALTED:  w_state_next = HALTED;
      default: w_state_next = RUN;
    endcase
  end

  // halt rises with the detecting edge; trap_valid pulses on entry to HALTED.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_halt       <= 1'b0;
      r_trap_valid <= 1'b0;
    end else begin
      r_halt       <= (w_state_next != RUN);
      r_trap_valid <= (r_state != HALTED) && (w_state_next == HALTED);
    end
  end

  // Drain counter restarts whenever we are not draining.
  always_ff @(posedge clk) begin
    if (rst || (r_state != DRAIN)) r_drain <= '0;
    else if (!w_drain_done)        r_drain <= r_drain + DRAIN_W'(1);
  end

  // No-progress watchdog and last retired pc, tracked only while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd      <= '0;
      r_last_pc <= '0;
    end else if (w_run) begin
      if (inst_valid) begin
        r_wd      <= '0;
        r_last_pc <= pc;
      end else if (!w_timeout) begin
        r_wd      <= r_wd + WD_W'(1);
      end
    end
  end

  // Capture trap information at the detecting edge; frozen afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_trap_code  <= TRAP_GOOD;
      r_exit_value <= '0;
      r_trap_pc    <= '0;
    end else if (w_inst_trap) begin
      r_trap_code  <= inst_trap_code(w_is_ecall, (a0 == '0));
      r_exit_value <= a0;
      r_trap_pc    <= pc;
    end else if (w_timeout) begin
      r_trap_code  <= TRAP_TIMEOUT;
      r_exit_value <= '0;
      r_trap_pc    <= r_last_pc;
    end
  end

  npc_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .en  (r_state != HALTED),
    .q   (cycle_cnt)
  );

  npc_sat_counter #(.W(CNT_W)) u_instret_cnt (
    .clk (clk),
    .rst (rst),
    .en  (w_retire),
    .q   (instret_cnt)
  );

  assign halt       = r_halt;
  assign trap_valid = r_trap_valid;
  assign trap_code  = r_trap_code;
  assign exit_value = r_exit_value;
  assign trap_pc    = r_trap_pc;

endmodule

// File: tb/tb_npc_trap_monitor.sv
// Bench for npc_trap_monitor: two configurations driven with shared stimulus
// and compared every cycle against an event-level reference model.
module tb_npc_trap_monitor;

  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam logic [31:0] ECALL  = 32'h00000073;
  localparam logic [31:0] NOP    = 32'h00000013;

  // Configuration A: drain 2, watchdog 8, ecall ignored.
  localparam int A_DRAIN = 2;
  localparam int A_TMO   = 8;
  localparam bit A_EC    = 1'b0;
  // Configuration B: no drain, watchdog 8, ecall halts.
  localparam int B_DRAIN = 0;
  localparam int B_TMO   = 8;
  localparam bit B_EC    = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst = NOP;
  logic        inst_valid = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] a0 = '0;

  logic        a_halt, a_tv, b_halt, b_tv;
  logic [1:0]  a_code, b_code;
  logic [31:0] a_exit, a_tpc, b_exit, b_tpc;
  logic [63:0] a_cyc, a_ins, b_cyc, b_ins;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  npc_trap_monitor #(.XLEN(32), .CNT_W(64), .DRAIN_CYCLES(A_DRAIN), .TIMEOUT(A_TMO), .ECALL_TRAP(0)) dut_a (
    .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid), .pc(pc), .a0(a0),
    .halt(a_halt), .trap_valid(a_tv), .trap_code(a_code), .exit_value(a_exit),
    .trap_pc(a_tpc), .cycle_cnt(a_cyc), .instret_cnt(a_ins)
  );

  npc_trap_monitor #(.XLEN(32), .CNT_W(64), .DRAIN_CYCLES(B_DRAIN), .TIMEOUT(B_TMO), .ECALL_TRAP(1)) dut_b (
    .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid), .pc(pc), .a0(a0),
    .halt(b_halt), .trap_valid(b_tv), .trap_code(b_code), .exit_value(b_exit),
    .trap_pc(b_tpc), .cycle_cnt(b_cyc), .instret_cnt(b_ins)
  );

  // Reference model: remembers the edge (counted from reset) at which a
  // halt was decided; everything else is derived from that edge number.
  typedef struct {
    int          e;
    bit          det;
    int          det_e;
    longint      cyc;
    longint      ins;
    int          wd;
    logic [31:0] lpc;
    logic [31:0] exv;
    logic [31:0] tpc;
    logic [1:0]  code;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.e = 0; m.det = 0; m.det_e = 0; m.cyc = 0; m.ins = 0; m.wd = 0;
    m.lpc = '0; m.exv = '0; m.tpc = '0; m.code = 2'd0;
    return m;
  endfunction

  function automatic mdl_t step(input mdl_t m, input int drain, input int tmo, input bit ec,
                                input logic r, input logic v, input logic [31:0] i,
                                input logic [31:0] p, input logic [31:0] a);
    mdl_t n;
    if (r) return mdl_reset();
    n = m;
    n.e = m.e + 1;
    if (!m.det) begin
      n.cyc = m.cyc + 1;
      if (v) begin
        n.ins = m.ins + 1;
        n.wd  = 0;
        n.lpc = p;
        if (i == EBREAK) begin
          n.det = 1; n.det_e = n.e; n.exv = a; n.tpc = p; n.code = (a == 0) ? 2'd0 : 2'd1;
        end else if (ec && i == ECALL) begin
          n.det = 1; n.det_e = n.e; n.exv = a; n.tpc = p; n.code = 2'd2;
        end
      end else if (tmo != 0 && m.wd == tmo - 1) begin
        n.det = 1; n.det_e = n.e; n.exv = '0; n.tpc = m.lpc; n.code = 2'd3;
      end else begin
        n.wd = m.wd + 1;
      end
    end else if (n.e <= m.det_e + drain) begin
      n.cyc = m.cyc + 1;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp(input string d, input mdl_t m, input int drain,
                     input logic h, input logic tv, input logic [1:0] c,
                     input logic [31:0] ev, input logic [31:0] tp,
                     input logic [63:0] cc, input logic [63:0] ic);
    check({d, ".halt"},        64'(h),  64'(m.det));
    check({d, ".trap_valid"},  64'(tv), 64'(m.det && (m.e == m.det_e + drain)));
    check({d, ".trap_code"},   64'(c),  64'(m.code));
    check({d, ".exit_value"},  64'(ev), 64'(m.exv));
    check({d, ".trap_pc"},     64'(tp), 64'(m.tpc));
    check({d, ".cycle_cnt"},   cc,      64'(m.cyc));
    check({d, ".instret_cnt"}, ic,      64'(m.ins));
  endtask

  // One clock edge: advance both models with the applied inputs, then compare.
  task automatic tick();
    @(posedge clk);
    ma = step(ma, A_DRAIN, A_TMO, A_EC, rst, inst_valid, inst, pc, a0);
    mb = step(mb, B_DRAIN, B_TMO, B_EC, rst, inst_valid, inst, pc, a0);
    #1;
    cmp("A", ma, A_DRAIN, a_halt, a_tv, a_code, a_exit, a_tpc, a_cyc, a_ins);
    cmp("B", mb, B_DRAIN, b_halt, b_tv, b_code, b_exit, b_tpc, b_cyc, b_ins);
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p, input logic [31:0] a);
    inst_valid = v; inst = i; pc = p; a0 = a;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, NOP, '0, '0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    ma = mdl_reset();
    mb = mdl_reset();

    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    check("reset.A.halt", 64'(a_halt), 64'd0);
    check("reset.A.cycle_cnt", a_cyc, 64'd0);
    rst = 1'b0;

    // Five retires then ebreak with a0=0 at edge 6.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, NOP, 32'h80000000 + 32'(4 * i), 32'(i + 1));
      tick();
    end
    drive(1'b1, EBREAK, 32'h80000014, 32'h0);
    tick();
    check("s1.A.halt_c7", 64'(a_halt), 64'd1);
    check("s1.A.tv_c7", 64'(a_tv), 64'd0);
    check("s1.B.tv_c7", 64'(b_tv), 64'd1);
    // Ebreaks during DRAIN/HALTED must be ignored.
    drive(1'b1, EBREAK, 32'h80000018, 32'h55);
    tick();
    check("s1.A.tv_c8", 64'(a_tv), 64'd0);
    tick();
    check("s1.A.tv_c9", 64'(a_tv), 64'd1);
    check("s1.A.cycle_cnt", a_cyc, 64'd8);
    check("s1.A.instret_cnt", a_ins, 64'd6);
    check("s1.A.trap_code", 64'(a_code), 64'd0);
    tick();
    check("s1.A.tv_c10", 64'(a_tv), 64'd0);
    check("s1.A.instret_hold", a_ins, 64'd6);
    check("s1.A.exit_hold", 64'(a_exit), 64'd0);
    drive(1'b0, NOP, '0, '0);
    tick();

    // Bad exit value, then reset in the middle of DRAIN.
    do_reset();
    drive(1'b1, NOP, 32'h8000000C, 32'h1);
    tick();
    drive(1'b1, EBREAK, 32'h80000010, 32'h0000002A);
    tick();
    check("s2.A.trap_code", 64'(a_code), 64'd1);
    check("s2.A.exit_value", 64'(a_exit), 64'h2A);
    check("s2.A.trap_pc", 64'(a_tpc), 64'h80000010);
    drive(1'b0, NOP, '0, '0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s2.A.halt_after_rst", 64'(a_halt), 64'd0);
    check("s2.A.exit_after_rst", 64'(a_exit), 64'd0);
    check("s2.A.cycle_after_rst", a_cyc, 64'd0);
    drive(1'b1, EBREAK, 32'h80000040, 32'h0);
    tick();
    drive(1'b0, NOP, '0, '0);
    tick();
    tick();
    check("s2.A.tv_after_rst", 64'(a_tv), 64'd1);

    // ecall: ignored by A, traps B.
    do_reset();
    drive(1'b1, NOP, 32'h80000000, 32'h3);
    tick();
    tick();
    drive(1'b1, ECALL, 32'h80000008, 32'h7);
    tick();
    check("s3.A.halt", 64'(a_halt), 64'd0);
    check("s3.A.instret_cnt", a_ins, 64'd3);
    check("s3.B.trap_code", 64'(b_code), 64'd2);
    check("s3.B.exit_value", 64'(b_exit), 64'd7);
    drive(1'b0, NOP, '0, '0);
    tick();

    // Watchdog: last retire then eight idle edges.
    do_reset();
    drive(1'b1, NOP, 32'h80000020, 32'h9);
    tick();
    drive(1'b0, NOP, 32'h80000024, 32'h9);
    for (int k = 1; k <= 7; k++) tick();
    check("s4.A.halt_idle8", 64'(a_halt), 64'd0);
    tick();
    check("s4.A.halt_idle9", 64'(a_halt), 64'd1);
    check("s4.A.trap_code", 64'(a_code), 64'd3);
    check("s4.A.exit_value", 64'(a_exit), 64'd0);
    check("s4.A.trap_pc", 64'(a_tpc), 64'h80000020);
    for (int k = 0; k < 4; k++) tick();

    // Randomised rounds with varying retire density.
    for (int r = 0; r < 9; r++) begin
      int vprob;
      vprob = (r % 3 == 0) ? 85 : ((r % 3 == 1) ? 50 : 20);
      do_reset();
      for (int c = 0; c < 120; c++) begin
        int sel;
        logic [31:0] iw;
        rst = ($urandom_range(0, 99) < 2);
        sel = $urandom_range(0, 19);
        iw  = (sel == 0) ? EBREAK : ((sel == 1) ? ECALL : ((sel < 10) ? NOP : $urandom));
        if ($urandom_range(0, 99) < vprob)
          drive(1'b1, iw, 32'h80000000 + ($urandom & 32'h0000FFFC),
                ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom);
        else
          drive(1'b0, 'x, $urandom, $urandom);
        tick();
      end
      rst = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/npc_trap_monitor.md
Name: npc_trap_monitor

Overview:
- Parametrised simulation-halt monitor placed beside riscv_cpu in the NPC simulation top.
- Generalises single-instruction ebreak detection: detects ebreak (and optionally ecall) on retired instructions, captures a0 and the trap PC, and drains for a configurable number of cycles so in-flight memory writes commit.
- Enters a sticky HALTED state and reports a trap code, cycle count and retired-instruction count.
- Adds a no-progress watchdog; the testbench wrapper issues its DPI call on trap_valid.

Parameters:
- XLEN, 32, width of a0, pc and exit_value.
- CNT_W, 64, width of cycle and instret counters.
- DRAIN_CYCLES, 2, cycles spent in DRAIN before HALTED (0 allowed).
- TIMEOUT, 100000, watchdog limit in cycles without a retired instruction; 0 disables the watchdog.
- ECALL_TRAP, 0, 1 = ecall (32'h00000073) also halts.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- inst  in  32  instruction retiring this cycle.
- inst_valid  in  1  inst retires this cycle.
- pc  in  XLEN  PC of inst.
- a0  in  XLEN  current value of register x10.
- halt  out  1  registered; CPU must stop fetching and retiring while high.
- trap_valid  out  1  one-cycle pulse on entry to HALTED.
- trap_code  out  2  0 GOOD (ebreak, a0==0), 1 BAD (ebreak, a0!=0), 2 ECALL, 3 TIMEOUT.
- exit_value  out  XLEN  a0 captured at detection; 0 for TIMEOUT.
- trap_pc  out  XLEN  pc captured at detection; last retired pc for TIMEOUT.
- cycle_cnt  out  CNT_W  cycles spent in RUN and DRAIN.
- instret_cnt  out  CNT_W  instructions retired in RUN.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=RUN; all outputs 0; watchdog counter 0.
  - Reset has priority over everything, including mid-DRAIN and HALTED.
- States: RUN, DRAIN, HALTED.
- RUN:
  - Every cycle: cycle_cnt += 1.
  - If inst_valid: instret_cnt += 1 (the trapping instruction is counted), watchdog cleared, last_pc <= pc.
  - Else: watchdog += 1.
- Trap detection in RUN at edge N requires inst_valid and either:
  - inst==32'h00100073 (ebreak), or
  - ECALL_TRAP=1 and inst==32'h00000073 (ecall).
- On detection at edge N:
  - Capture a0 into exit_value and pc into trap_pc.
  - Set code: GOOD if a0==0, BAD if a0!=0, ECALL for ecall regardless of a0.
  - halt=1 from cycle N+1.
  - Next state is DRAIN, or HALTED if DRAIN_CYCLES=0.
- Timeout: in RUN, if TIMEOUT!=0, inst_valid=0 and watchdog==TIMEOUT-1 at an edge:
  - code=TIMEOUT, exit_value=0, trap_pc=last_pc.
  - Same halt/drain path as a trap.
- Simultaneous valid ebreak/ecall and watchdog expiry: the instruction trap wins (watchdog is cleared by inst_valid anyway).
- DRAIN:
  - cycle_cnt still increments; inst_valid is ignored (no instret, no detection).
  - Drain counter runs 0..DRAIN_CYCLES-1, then the state becomes HALTED.
  - First HALTED cycle is N+1+DRAIN_CYCLES.
- HALTED:
  - trap_valid=1 for exactly the first cycle only.
  - halt stays 1; all counters and captured values frozen; all inputs ignored until rst.
- Counters saturate at all-ones and do not wrap; the watchdog is sized to TIMEOUT.
- Counter outputs are registered; values seen in cycle k reflect edges up to k.
- X/Z on inst while inst_valid=0: no effect.

Decomposition:
- Package npc_sim_pkg holds:
  - state enum {RUN, DRAIN, HALTED};
  - trap_code constants TRAP_GOOD/TRAP_BAD/TRAP_ECALL/TRAP_TIMEOUT;
  - INST_EBREAK=32'h00100073, INST_ECALL=32'h00000073.
- Sub-module npc_sat_counter (params W; inputs clk, rst, en; output q, saturating), instantiated for cycle_cnt and instret_cnt.

Test Plan:
- 5 retires then ebreak with a0=0 (DRAIN_CYCLES=2), detection at edge 6 -> halt=1 from cycle 7, trap_valid pulse at cycle 9 only, trap_code=0, instret_cnt=6, cycle_cnt=8.
- ebreak with a0=32'h0000002A at pc=32'h80000010 -> trap_code=1, exit_value=0x2A, trap_pc=0x80000010.
- ecall with ECALL_TRAP=0 -> no halt, instret counts it; same stimulus with ECALL_TRAP=1 -> trap_code=2.
- TIMEOUT=8, inst_valid held 0 after last retire at pc=0x80000020 -> halt from the 9th idle cycle, trap_code=3, exit_value=0, trap_pc=0x80000020.
- rst asserted during DRAIN -> next cycle state RUN, all outputs 0; a following ebreak halts normally.
- inst_valid=1 with ebreak during DRAIN and in HALTED -> ignored; instret_cnt and exit_value unchanged; no second trap_valid pulse.
